gain_shift_encoder: RTL and testbench

- Converts an unsigned fixed-point gain word into the four 4-bit shift codes (a, b, c, d) consumed by the shift-add attenuator in the audio path. The attenuator computes out = sample * (2^-a + 2^-b + 2^-c + 2^-d).
- Sits between the volume/envelope control logic and the attenuator.
- Greedy-encodes the up-to-four most significant set bits of the gain, scanning one bit per clock.
- Holds the last codes stable until a new encode completes.

---
 rtl/gain_shift_encoder_if.sv | 26 ++
 rtl/gain_shift_encoder.sv | 121 ++++++++++++
 tb/tb_gain_shift_encoder.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/gain_shift_encoder_if.sv
// Control-side bundle between the volume/envelope logic and the gain shift encoder.
// The encoder owns busy/done/codes; the controller owns start/gain.
interface gain_shift_encoder_if #(
    parameter int GAIN_W = 9
);
    logic              start;
    logic [GAIN_W-1:0] gain;
    logic              busy;
    logic              done;
    logic [3:0]        a;
    logic [3:0]        b;
    logic [3:0]        c;
    logic [3:0]        d;
    logic              exact;
    logic              mute;

    modport master (
        output start, gain,
        input  busy, done, a, b, c, d, exact, mute
    );

    modport slave (
        input  start, gain,
        output busy, done, a, b, c, d, exact, mute
    );
endinterface

// File: rtl/gain_shift_encoder.sv
// Greedy encoder: scans a Q1.(GAIN_W-1) gain MSB-first, one bit per clock, and emits
// up to four shift codes for the shift-add attenuator. Codes change only when a scan completes.
module gain_shift_encoder #(
    parameter int GAIN_W = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    gain_shift_encoder_if.slave  bus
);
    localparam int IDX_W = (GAIN_W > 1) ? $clog2(GAIN_W) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        FINISH
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [GAIN_W-1:0] r_gain;
    logic [IDX_W-1:0]  r_idx;
    logic [2:0]        r_cnt;
    logic [3:0][3:0]   r_slot;
    logic              r_drop;
    logic              r_busy;
    logic              r_done;
    logic [3:0]        r_a;
    logic [3:0]        r_b;
    logic [3:0]        r_c;
    logic [3:0]        r_d;
    logic              r_exact;
    logic              r_mute;

    logic              w_accept;
    logic              w_bit;
    logic              w_last;
    logic [3:0]        w_shift;

    assign w_bit   = r_gain[r_idx];
    assign w_last  = (r_idx == '0);
    assign w_shift = 4'(GAIN_W - 1) - 4'(r_idx);

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next   = SCAN;
                    w_accept = 1'b1;
                end
            end
            SCAN: begin
                if (w_last) w_next = FINISH;
            end
            FINISH: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_gain  <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_slot  <= '1;
            r_drop  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_a     <= 4'd0;
            r_b     <= 4'hF;
            r_c     <= 4'hF;
            r_d     <= 4'hF;
            r_exact <= 1'b1;
            r_mute  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= 1'b0;
            if (w_accept) begin
                r_gain <= bus.gain;
                r_idx  <= IDX_W'(GAIN_W - 1);
                r_cnt  <= '0;
                r_slot <= '1;
                r_drop <= 1'b0;
                r_busy <= 1'b1;
            end
            if (r_state == SCAN) begin
                if (w_bit) begin
                    if (r_cnt < 3'd4) begin
                        r_slot[r_cnt[1:0]] <= w_shift;
                        r_cnt              <= r_cnt + 3'd1;
                    end else begin
                        r_drop <= 1'b1;
                    end
                end
                if (!w_last) r_idx <= r_idx - 1'b1;
            end
            // Working slots start at 15, so an empty scan naturally yields a=15.
            if (r_state == FINISH) begin
                r_a     <= r_slot[0];
                r_b     <= r_slot[1];
                r_c     <= r_slot[2];
                r_d     <= r_slot[3];
                r_exact <= ~r_drop;
                r_mute  <= (r_cnt == 3'd0);
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
            end
        end
    end

    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.a     = r_a;
    assign bus.b     = r_b;
    assign bus.c     = r_c;
    assign bus.d     = r_d;
    assign bus.exact = r_exact;
    assign bus.mute  = r_mute;
endmodule

// File: tb/tb_gain_shift_encoder.sv
// Scoreboard bench for gain_shift_encoder: driver pushes model results, monitor
// pops them on done and also checks that the codes are held between encodes.
module tb_gain_shift_encoder;
    localparam int GW  = 9;
    localparam int LAT = GW + 1;

    typedef struct {
        logic [3:0] a, b, c, d;
        logic       exact, mute;
        int         acc;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q[$];
    exp_t held;

    gain_shift_encoder_if #(.GAIN_W(GW)) bus ();

    gain_shift_encoder #(.GAIN_W(GW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [GW-1:0] g, input int acc);
        exp_t e;
        int   sh[$];
        logic [3:0] slots [4];
        for (int i = 0; i < 4; i++) slots[i] = 4'd15;
        for (int s = 0; s < GW; s++)
            if (g[GW-1-s]) sh.push_back(s);
        for (int i = 0; i < 4 && i < sh.size(); i++) slots[i] = 4'(sh[i]);
        e.a = slots[0]; e.b = slots[1]; e.c = slots[2]; e.d = slots[3];
        e.exact = (sh.size() <= 4);
        e.mute  = (sh.size() == 0);
        e.acc   = acc;
        return e;
    endfunction

    function automatic int atten(input int sample, input logic [3:0] a, b, c, d);
        int r = 0;
        if (a != 4'd15) r += sample >> a;
        if (b != 4'd15) r += sample >> b;
        if (c != 4'd15) r += sample >> c;
        if (d != 4'd15) r += sample >> d;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp_v);
        end
    endtask

    function automatic logic [31:0] pack_dut();
        return {14'd0, bus.a, bus.b, bus.c, bus.d, bus.exact, bus.mute};
    endfunction

    function automatic logic [31:0] pack_exp(input exp_t e);
        return {14'd0, e.a, e.b, e.c, e.d, e.exact, e.mute};
    endfunction

    // Monitor: samples 2 time units after each rising edge.
    initial begin
        exp_t e;
        held = model('0, 0);
        held.a = 4'd0; held.mute = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #2;
            if (reset) begin
                q.delete();
                held.a = 4'd0; held.b = 4'hF; held.c = 4'hF; held.d = 4'hF;
                held.exact = 1'b1; held.mute = 1'b0;
                check("reset_codes", pack_dut(), pack_exp(held));
                check("reset_busy_done", {30'd0, bus.busy, bus.done}, 32'd0);
            end else begin
                if (bus.done === 1'b1) begin
                    if (q.size() == 0) begin
                        check("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = q.pop_front();
                        held = e;
                        check("latency", 32'(cyc - e.acc), 32'(LAT));
                        check("done_busy", {31'd0, bus.busy}, 32'd0);
                    end
                end
                check("codes", pack_dut(), pack_exp(held));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (bus.busy !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic encode(input logic [GW-1:0] g);
        wait_idle();
        bus.gain  = g;
        bus.start = 1'b1;
        q.push_back(model(g, cyc + 1));
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("drain_timeout", 32'(q.size()), 32'd0);
        q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [GW-1:0] g;
        bus.start = 1'b0;
        bus.gain  = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        encode(9'h100); drain();
        encode(9'h0C0); drain();
        check("atten_750", 32'(atten(1000, bus.a, bus.b, bus.c, bus.d)), 32'd750);
        encode(9'h0FF); drain();

        // Gain input changes mid-scan must not affect the captured value.
        encode(9'h181);
        repeat (2) @(negedge clk);
        bus.gain = 9'h000;
        drain();

        encode(9'h000); drain();

        // Ignored start during scan, then reset on the 5th scan cycle.
        encode(9'h0C0);
        repeat (2) @(negedge clk);
        bus.gain  = 9'h001;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        encode(9'h001); drain();

        // start held high: back-to-back encodes spaced GW+2 edges apart.
        wait_idle();
        bus.start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            g = GW'($urandom);
            bus.gain = g;
            q.push_back(model(g, cyc + 1));
            repeat (GW + 2) @(negedge clk);
        end
        bus.start = 1'b0;
        drain();

        for (int i = 0; i < 20; i++) begin
            g = GW'($urandom);
            encode(g);
            if ($urandom_range(1, 0) == 1) begin
                repeat ($urandom_range(8, 1)) @(negedge clk);
                bus.gain  = GW'($urandom);
                bus.start = 1'b1;
                @(negedge clk);
                bus.start = 1'b0;
            end
            drain();
            repeat ($urandom_range(3, 0)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
